// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one fixed-latency, single-ported memory between instruction fetch
// and load/store. Data has priority; fetch is guaranteed a grant after STARVE_MAX data wins.
module unified_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    // state  | meaning
    // IDLE   | no access in flight; arbitration and issue happen here
    // BUSY_I | fetch access in flight, waiting for mem_rdata
    // BUSY_D | data access in flight, waiting for mem_rdata (or store completion)
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BUSY_I = 2'd1;
    localparam logic [1:0] S_BUSY_D = 2'd2;

    localparam int LAT_W = $clog2(MEM_LAT + 1);
    localparam int STV_W = $clog2(STARVE_MAX + 1);

    localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT);
    localparam logic [STV_W-1:0] STV_ONE  = STV_W'(1);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_MAX);

    logic [1:0]       state;
    logic [LAT_W-1:0] lat_cnt;
    logic [STV_W-1:0] starve_cnt;
    logic             we_q;

    logic grant_d;
    logic issue;
    logic lat_last;

    always_comb begin
        grant_d  = d_req && !(if_req && (starve_cnt == STV_MAX));
        issue    = !reset && (state == S_IDLE) && (if_req || d_req);
        lat_last = (lat_cnt == LAT_ONE);
    end

    // Issue side is Mealy: the winner's request is presented to memory in the same cycle.
    always_comb begin
        mem_valid = issue;
        mem_we    = issue && grant_d && d_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (issue) begin
            mem_addr = grant_d ? d_addr : if_addr;
            if (grant_d) begin
                mem_wdata = d_wdata;
            end
        end
    end

    always_comb begin
        if_ready = !reset && (state == S_BUSY_I) && lat_last;
        d_ready  = !reset && (state == S_BUSY_D) && lat_last;
        if_rdata = if_ready ? mem_rdata : '0;
        d_rdata  = (d_ready && !we_q) ? mem_rdata : '0;
        busy     = !reset && (state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            lat_cnt    <= '0;
            starve_cnt <= '0;
            we_q       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!if_req) begin
                        starve_cnt <= '0;
                    end else if (!grant_d) begin
                        starve_cnt <= '0;
                    end else if (starve_cnt != STV_MAX) begin
                        starve_cnt <= starve_cnt + STV_ONE;
                    end
                    if (issue) begin
                        state   <= grant_d ? S_BUSY_D : S_BUSY_I;
                        lat_cnt <= LAT_LOAD;
                        we_q    <= grant_d && d_we;
                    end
                end
                S_BUSY_I, S_BUSY_D: begin
                    lat_cnt <= lat_cnt - LAT_ONE;
                    if (lat_last) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
